// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller: FSM states,
// default halt opcode and the byte order used when packing loader bytes into words.
package instr_fetch_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] HALT_OPC_DEF = 8'hFF;

    // Loader streams the low byte of each word first.
    localparam bit LO_BYTE_FIRST = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_LO   = 3'd1,
        S_LD_HI   = 3'd2,
        S_WRITE   = 3'd3,
        S_RD_ADDR = 3'd4,
        S_RD_CAP  = 3'd5,
        S_HOLD    = 3'd6,
        S_DONE    = 3'd7
    } state_t;

endpackage

// File: rtl/instr_word_packer.sv
// Collects loader bytes into an instr_mem write word and, when LOAD_CKSUM_EN is
// defined, keeps a wrapping byte sum of the current load (cksum tied to zero otherwise).
module instr_word_packer
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int unsigned WDATA_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               take_lo,
    input  logic               take_hi,
    input  logic               pad_hi,
    input  logic [BYTE_W-1:0]  byte_in,
    output logic [WDATA_W-1:0] word,
    output logic [BYTE_W-1:0]  cksum
);

    logic [BYTE_W-1:0] lo_byte;
    logic [BYTE_W-1:0] hi_byte;

    // Byte holding registers; a low byte flagged last forces the high byte to zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lo_byte <= '0;
            hi_byte <= '0;
        end else begin
            if (take_lo) begin
                lo_byte <= byte_in;
                if (pad_hi) begin
                    hi_byte <= '0;
                end
            end
            if (take_hi) begin
                hi_byte <= byte_in;
            end
        end
    end

    assign word = LO_BYTE_FIRST ? WDATA_W'({hi_byte, lo_byte}) : WDATA_W'({lo_byte, hi_byte});

`ifdef LOAD_CKSUM_EN
    logic [BYTE_W-1:0] sum;

    // The pad byte is zero, so it never changes the sum.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum <= '0;
        end else if (take_lo || take_hi) begin
            sum <= sum + byte_in;
        end
    end

    assign cksum = sum;
`else
    assign cksum = '0;
`endif

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Owner of the instr_mem ports: LOAD packs host bytes into words from address 0,
// RUN fetches from PC and hands instructions to the core. Optional LOAD_CKSUM_EN adds a load checksum.
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 8,
    parameter int unsigned        WDATA_W  = 16,
    parameter int unsigned        RDATA_W  = 8,
    parameter logic [RDATA_W-1:0] HALT_OPC = RDATA_W'(HALT_OPC_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_start,
    input  logic               ld_valid,
    input  logic [BYTE_W-1:0]  ld_byte,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic               ld_err,
    input  logic               run,
    output logic [RDATA_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               pc_jump,
    input  logic [ADDR_W-1:0]  pc_target,
    output logic               done,
    output logic [ADDR_W:0]    prog_len,
    output logic [BYTE_W-1:0]  ld_cksum,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_w_addr,
    output logic [WDATA_W-1:0] mem_w_instr,
    output logic [ADDR_W-1:0]  mem_r_addr,
    input  logic [RDATA_W-1:0] mem_r_instr
);

    localparam int unsigned   PROG_W   = ADDR_W + 1;
    localparam logic [ADDR_W:0] PROG_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pc_next;
    logic [ADDR_W:0]     prog_len_next;
    logic                ld_err_next;
    logic                last_seen;
    logic                last_next;
    logic [RDATA_W-1:0]  instr_next;
    logic [ADDR_W-1:0]   instr_pc_next;
    logic                pk_clear;
    logic                take_lo;
    logic                take_hi;
    logic                pad_hi;
    logic                accept;
    logic                full;

    assign accept     = ld_valid & ld_ready;
    assign full       = (prog_len == PROG_MAX);
    assign mem_w_addr = prog_len[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath update selection.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        prog_len_next = prog_len;
        ld_err_next   = ld_err;
        last_next     = last_seen;
        instr_next    = instr;
        instr_pc_next = instr_pc;
        pk_clear      = 1'b0;
        take_lo       = 1'b0;
        take_hi       = 1'b0;
        pad_hi        = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_start) begin
                    state_next    = S_LD_LO;
                    pk_clear      = 1'b1;
                    prog_len_next = '0;
                    ld_err_next   = 1'b0;
                    last_next     = 1'b0;
                end else if (run) begin
                    state_next = S_RD_ADDR;
                    pc_next    = '0;
                end
            end
            S_LD_LO: begin
                if (accept) begin
                    take_lo   = 1'b1;
                    last_next = ld_last;
                    if (ld_last) begin
                        pad_hi     = 1'b1;
                        state_next = S_WRITE;
                    end else begin
                        state_next = S_LD_HI;
                    end
                end
            end
            S_LD_HI: begin
                if (accept) begin
                    take_hi    = 1'b1;
                    last_next  = ld_last;
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                // A full memory still drains bytes but only flags the overflow.
                if (full) begin
                    ld_err_next = 1'b1;
                end else begin
                    prog_len_next = prog_len + PROG_W'(1);
                end
                state_next = last_seen ? S_IDLE : S_LD_LO;
            end
            S_RD_ADDR: begin
                state_next = ({1'b0, pc} >= prog_len) ? S_DONE : S_RD_CAP;
            end
            S_RD_CAP: begin
                if (mem_r_instr == HALT_OPC) begin
                    state_next = S_DONE;
                end else begin
                    state_next    = S_HOLD;
                    instr_next    = mem_r_instr;
                    instr_pc_next = pc;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    pc_next    = pc_jump ? pc_target : pc + ADDR_W'(1);
                    state_next = S_RD_ADDR;
                end
            end
            S_DONE: begin
                if (run) begin
                    state_next = S_RD_ADDR;
                    pc_next    = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Registered outputs follow the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            prog_len    <= '0;
            ld_err      <= 1'b0;
            last_seen   <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
            ld_ready    <= 1'b0;
            mem_we      <= 1'b0;
            mem_r_addr  <= '0;
        end else begin
            pc          <= pc_next;
            prog_len    <= prog_len_next;
            ld_err      <= ld_err_next;
            last_seen   <= last_next;
            instr       <= instr_next;
            instr_pc    <= instr_pc_next;
            instr_valid <= (state_next == S_HOLD);
            done        <= (state_next == S_DONE);
            ld_ready    <= (state_next == S_LD_LO) || (state_next == S_LD_HI);
            mem_we      <= (state_next == S_WRITE) && !full;
            if (state_next == S_RD_ADDR) begin
                mem_r_addr <= pc_next;
            end
        end
    end

    instr_word_packer #(
        .WDATA_W (WDATA_W)
    ) u_packer (
        .clk     (clk),
        .rst     (rst),
        .clear   (pk_clear),
        .take_lo (take_lo),
        .take_hi (take_hi),
        .pad_hi  (pad_hi),
        .byte_in (ld_byte),
        .word    (mem_w_instr),
        .cksum   (ld_cksum)
    );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: randomized loads and runs against a
// transaction-level model (expected write list, PC walk over a byte memory).
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_err;
    logic        run;
    logic [7:0]  instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_jump;
    logic [7:0]  pc_target;
    logic        done;
    logic [8:0]  prog_len;
    logic [7:0]  ld_cksum;
    logic        mem_we;
    logic [7:0]  mem_w_addr;
    logic [15:0] mem_w_instr;
    logic [7:0]  mem_r_addr;
    logic [7:0]  mem_r_instr;

    instr_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .ld_valid    (ld_valid),
        .ld_byte     (ld_byte),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .ld_err      (ld_err),
        .run         (run),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_jump     (pc_jump),
        .pc_target   (pc_target),
        .done        (done),
        .prog_len    (prog_len),
        .ld_cksum    (ld_cksum),
        .mem_we      (mem_we),
        .mem_w_addr  (mem_w_addr),
        .mem_w_instr (mem_w_instr),
        .mem_r_addr  (mem_r_addr),
        .mem_r_instr (mem_r_instr)
    );

    always #5 clk = ~clk;

    // Read side of instr_mem: one-cycle registered read.
    logic [7:0] rmem [256];
    always @(posedge clk) mem_r_instr <= rmem[mem_r_addr];

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [23:0] exp_wr [$];
    logic [23:0] wr_log [$];
    logic [15:0] dlv_log [$];
    logic [7:0]  pbytes [$];
    int          jq_idx [$];
    logic [7:0]  jq_tgt [$];
    int          m_prog_len;
    bit          m_err;
    logic [7:0]  m_ck;
    int          nd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    function automatic bit halts(input int pc);
        return (pc >= m_prog_len) || (rmem[pc] == 8'hFF);
    endfunction

    // Every write must match the next expected (addr, word) pair.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            chk("mem_we expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0)
                chk("mem write addr/data", 32'({mem_w_addr, mem_w_instr}), 32'(exp_wr.pop_front()));
            wr_log.push_back({mem_w_addr, mem_w_instr});
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; load_start = 1'b0; ld_valid = 1'b0; ld_byte = 8'h00; ld_last = 1'b0;
        run = 1'b0; instr_ready = 1'b0; pc_jump = 1'b0; pc_target = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("rst ld_ready", 32'(ld_ready), 32'd0);
        chk("rst ld_err", 32'(ld_err), 32'd0);
        chk("rst instr", 32'(instr), 32'd0);
        chk("rst instr_pc", 32'(instr_pc), 32'd0);
        chk("rst instr_valid", 32'(instr_valid), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst prog_len", 32'(prog_len), 32'd0);
        chk("rst ld_cksum", 32'(ld_cksum), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_w_addr", 32'(mem_w_addr), 32'd0);
        chk("rst mem_w_instr", 32'(mem_w_instr), 32'd0);
        chk("rst mem_r_addr", 32'(mem_r_addr), 32'd0);
        rst = 1'b0;
        m_prog_len = 0; m_err = 1'b0; m_ck = 8'h00;
        jq_idx.delete(); jq_tgt.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        int n;
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) begin
            ld_valid = 1'b0;
            run = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        run = 1'b0; ld_valid = 1'b1; ld_byte = b; ld_last = last;
        n = 0;
        while (ld_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ld_ready within bound", 32'(n < 20), 32'd1);
        @(posedge clk);
    endtask

    task automatic load_prog(input bit with_run);
        int n;
        logic [7:0] lo;
        logic [7:0] hi;
        n = pbytes.size();
        exp_wr.delete(); wr_log.delete();
        m_prog_len = 0; m_err = 1'b0; m_ck = 8'h00;
        for (int i = 0; i < n; i += 2) begin
            lo = pbytes[i];
            hi = (i + 1 < n) ? pbytes[i+1] : 8'h00;
            m_ck = m_ck + lo + hi;
            if (m_prog_len < 256) begin
                exp_wr.push_back({8'(m_prog_len), hi, lo});
                m_prog_len++;
            end else begin
                m_err = 1'b1;
            end
        end
        @(negedge clk);
        load_start = 1'b1; run = with_run;
        @(negedge clk);
        load_start = 1'b0; run = 1'b0;
        chk("ld_ready after load_start", 32'(ld_ready), 32'd1);
        chk("done after load_start", 32'(done), 32'd0);
        for (int i = 0; i < n; i++) send_byte(pbytes[i], i == n - 1);
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("prog_len", 32'(prog_len), 32'(m_prog_len));
        chk("ld_err", 32'(ld_err), 32'(m_err));
`ifdef LOAD_CKSUM_EN
        chk("ld_cksum", 32'(ld_cksum), 32'(m_ck));
`else
        chk("ld_cksum", 32'(ld_cksum), 32'd0);
`endif
        chk("writes outstanding", 32'(exp_wr.size()), 32'd0);
        chk("ld_ready back in IDLE", 32'(ld_ready), 32'd0);
    endtask

    task automatic fill_rmem(input int halt_odds);
        for (int i = 0; i < 256; i++)
            rmem[i] = (halt_odds != 0 && $urandom_range(0, halt_odds) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
    endtask

    task automatic run_prog(input bit rand_jump, input int min_hold, input bit chk_rate, output int ndel);
        int cyc, held, last_hs, m_pc;
        bit seen, r, j;
        logic [7:0] t, h_instr, h_pc;
        cyc = 0; held = 0; last_hs = -1; m_pc = 0; seen = 1'b0; ndel = 0;
        h_instr = 8'h00; h_pc = 8'h00;
        dlv_log.delete();
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        while (done !== 1'b1 && cyc < 4000) begin
            r = 1'($urandom_range(0, 1));
            j = 1'($urandom_range(0, 1));
            t = 8'($urandom);
            if (instr_valid === 1'b1) begin
                if (!seen) begin
                    chk("valid only when model continues", 32'(halts(m_pc)), 32'd0);
                    chk("instr_pc", 32'(instr_pc), 32'(m_pc));
                    chk("instr", 32'(instr), 32'(rmem[m_pc]));
                    if (chk_rate && last_hs >= 0)
                        chk("cycles between handshakes", 32'(cyc - last_hs), 32'd3);
                    dlv_log.push_back({instr_pc, instr});
                    h_instr = instr; h_pc = instr_pc; seen = 1'b1; held = 0;
                end else begin
                    chk("instr held stable", 32'({instr_pc, instr}), 32'({h_pc, h_instr}));
                end
                held++;
                r = (held > min_hold) && (chk_rate || $urandom_range(0, 2) == 0);
                if (r) begin
                    j = 1'b0;
                    if (jq_idx.size() != 0 && jq_idx[0] == ndel) begin
                        j = 1'b1; t = jq_tgt.pop_front(); void'(jq_idx.pop_front());
                    end else if (rand_jump && ndel < 30 && $urandom_range(0, 3) == 0) begin
                        j = 1'b1; t = 8'($urandom_range(0, m_prog_len + 3));
                    end
                    m_pc = j ? int'(t) : (m_pc + 1) % 256;
                    ndel++; seen = 1'b0; last_hs = cyc;
                end
            end
            instr_ready = r; pc_jump = j; pc_target = t;
            @(negedge clk);
            cyc++;
        end
        instr_ready = 1'b0; pc_jump = 1'b0;
        chk("run ends within bound", 32'(cyc < 4000), 32'd1);
        chk("done only when model halts", 32'(halts(m_pc)), 32'd1);
        chk("instr_valid low in DONE", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; ld_valid = 1'b0; ld_byte = 8'h00; ld_last = 1'b0;
        run = 1'b0; instr_ready = 1'b0; pc_jump = 1'b0; pc_target = 8'h00;
        for (int i = 0; i < 256; i++) rmem[i] = 8'h00;
        do_reset();

        // Even-length load.
        pbytes = {8'h11, 8'h22, 8'h33, 8'h44};
        load_prog(1'b0);
        chk("writes for 4-byte load", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() >= 2) begin
            chk("word 0 literal", 32'(wr_log[0]), 32'h002211);
            chk("word 1 literal", 32'(wr_log[1]), 32'h014433);
        end
        chk("prog_len literal", 32'(prog_len), 32'd2);

        // Odd-length load pads the high byte.
        pbytes = {8'hAA, 8'hBB, 8'hCC};
        load_prog(1'b0);
        if (wr_log.size() >= 2) chk("padded word literal", 32'(wr_log[1]), 32'h0100CC);
`ifdef LOAD_CKSUM_EN
        chk("cksum literal", 32'(ld_cksum), 32'h31);
`endif

        // Halt opcode ends the run and is never delivered.
        pbytes.delete();
        for (int i = 0; i < 6; i++) pbytes.push_back(8'($urandom));
        load_prog(1'b0);
        fill_rmem(0);
        rmem[0] = 8'h05; rmem[1] = 8'h06; rmem[2] = 8'hFF;
        run_prog(1'b0, 0, 1'b1, nd);
        chk("deliveries before halt", 32'(nd), 32'd2);
        if (dlv_log.size() >= 2) begin
            chk("first delivery literal", 32'(dlv_log[0]), 32'h0005);
            chk("second delivery literal", 32'(dlv_log[1]), 32'h0106);
        end
        chk("done after halt", 32'(done), 32'd1);

        // load_start is ignored in DONE.
        @(negedge clk); load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        chk("load_start ignored in DONE", 32'(ld_ready), 32'd0);
        chk("still done", 32'(done), 32'd1);

        // Restart from DONE with long stalls and off-handshake jump noise.
        run_prog(1'b0, 5, 1'b0, nd);
        chk("deliveries with stalls", 32'(nd), 32'd2);

        // Jump on handshake at PC 3.
        do_reset();
        pbytes.delete();
        for (int i = 0; i < 40; i++) pbytes.push_back(8'($urandom));
        load_prog(1'b0);
        fill_rmem(0);
        jq_idx = {3}; jq_tgt = {8'h10};
        run_prog(1'b0, 0, 1'b1, nd);
        chk("deliveries with jump", 32'(nd), 32'd8);
        if (dlv_log.size() >= 5) chk("pc after jump literal", 32'(dlv_log[4][15:8]), 32'h10);

        // Randomized load/run rounds.
        for (int k = 0; k < 6; k++) begin
            do_reset();
            pbytes.delete();
            for (int i = 0; i < int'($urandom_range(1, 60)); i++) pbytes.push_back(8'($urandom));
            load_prog(1'($urandom_range(0, 1)));
            fill_rmem(15);
            run_prog(1'b1, int'($urandom_range(0, 2)), 1'b0, nd);
        end

        // Full memory: PC 0xFF wraps to 0.
        do_reset();
        pbytes.delete();
        for (int i = 0; i < 512; i++) pbytes.push_back(8'($urandom));
        load_prog(1'b0);
        chk("prog_len full literal", 32'(prog_len), 32'd256);
        fill_rmem(0);
        rmem[5] = 8'hFF;
        jq_idx = {0, 2}; jq_tgt = {8'hFF, 8'h05};
        run_prog(1'b0, 0, 1'b1, nd);
        chk("deliveries across wrap", 32'(nd), 32'd3);
        if (dlv_log.size() >= 3) begin
            chk("pc 0xFF delivered", 32'(dlv_log[1][15:8]), 32'hFF);
            chk("pc wrapped to 0", 32'(dlv_log[2][15:8]), 32'h00);
        end

        // Overflowing load: 257 words.
        do_reset();
        pbytes.delete();
        for (int i = 0; i < 514; i++) pbytes.push_back(8'($urandom));
        load_prog(1'b0);
        chk("ld_err literal", 32'(ld_err), 32'd1);
        chk("writes capped literal", 32'(wr_log.size()), 32'd256);

        // Reset while in WRITE.
        do_reset();
        exp_wr.delete(); wr_log.delete();
        @(negedge clk); load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        exp_wr.push_back(24'h003412);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        #1 rst = 1'b1; ld_valid = 1'b0;
        @(negedge clk);
        chk("mem_we in WRITE", 32'(mem_we), 32'd1);
        @(negedge clk);
        chk("mem_we after reset", 32'(mem_we), 32'd0);
        chk("ld_ready after reset", 32'(ld_ready), 32'd0);
        chk("prog_len after reset", 32'(prog_len), 32'd0);
        rst = 1'b0;
        m_prog_len = 0; m_err = 1'b0; m_ck = 8'h00;
        repeat (2) @(negedge clk);
        chk("single write logged", 32'(wr_log.size()), 32'd1);

        // load_start and run together: load wins.
        pbytes = {8'h56};
        load_prog(1'b1);
        if (wr_log.size() >= 1) chk("single padded word", 32'(wr_log[0]), 32'h000056);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
